// File: rtl/nf10_ip_pkg.sv
// Shared IPv4 header constants, packet FSM state type and one's-complement fold helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nf10_ip_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;

  // Byte offsets within beat 0 (byte 0 is the most significant byte of TDATA).
  localparam int ETHTYPE_OFF  = 12;
  localparam int IP_START_OFF = 14;
  localparam int TTL_OFF      = 22;
  localparam int CSUM_OFF     = 24;

  // A 20-byte header is 10 16-bit words; TTL sits in the high byte of word 4,
  // the checksum field is word 5.
  localparam int HDR_WORDS = 10;
  localparam int TTL_WORD  = (TTL_OFF - IP_START_OFF) / 2;
  localparam int CSUM_WORD = (CSUM_OFF - IP_START_OFF) / 2;

  localparam int BAD_CSUM_POS_DEF = 32;
  localparam int TTL_EXP_POS_DEF  = 33;

  typedef enum logic {
    ST_SOP  = 1'b0,
    ST_BODY = 1'b1
  } pkt_state_e;

  // Ten 16-bit words sum to at most 20 bits. The first fold can still carry
  // out of bit 15; the second fold absorbs that carry and cannot carry again.
  function automatic logic [15:0] ones_fold16(input logic [19:0] sum);
    logic [16:0] f1;
    f1 = {1'b0, sum[15:0]} + {13'b0, sum[19:16]};
    ones_fold16 = f1[15:0] + {15'b0, f1[16]};
  endfunction

endpackage

// File: rtl/ip_hdr_csum.sv
// IPv4 header checksum verify and recompute for a TTL decrement.
// Latency: combinational.
// Backpressure: none (no state).
// Ports: hdr_w_i  - ten header words, index 0 = first header word (version/IHL/TOS)
//        csum_ok_o  - one's-complement sum of all ten words folds to 16'hFFFF
//        new_csum_o - checksum to write after TTL is decremented by one
module ip_hdr_csum
  import nf10_ip_pkg::*;
(
  input  logic [HDR_WORDS-1:0][15:0] hdr_w_i,
  output logic                       csum_ok_o,
  output logic [15:0]                new_csum_o
);

  logic [19:0] sum_rx;
  logic [19:0] sum_tx;

  always_comb begin
    sum_rx = '0;
    sum_tx = '0;
    for (int i = 0; i < HDR_WORDS; i++) begin
      sum_rx = sum_rx + 20'(hdr_w_i[i]);
      // New sum: TTL byte minus one, checksum field taken as zero.
      if (i == TTL_WORD) begin
        sum_tx = sum_tx + 20'(hdr_w_i[i] - 16'h0100);
      end else if (i != CSUM_WORD) begin
        sum_tx = sum_tx + 20'(hdr_w_i[i]);
      end
    end
    csum_ok_o  = (ones_fold16(sum_rx) == 16'hFFFF);
    new_csum_o = ~ones_fold16(sum_tx);
  end

endmodule

// File: rtl/ip_ttl_checksum_update.sv
// AXI4-Stream IPv4 stage: verifies header checksum, decrements TTL, flags bad/expired packets in TUSER.
// Latency: a beat leaves one cycle after its successor is accepted; a last beat one cycle after its own acceptance.
// Backpressure: S_AXIS_TREADY = !out_valid || M_AXIS_TREADY; full throughput of one beat per cycle.
// Ports: AXI_ACLK/AXI_RESETN clock and async active-low reset; S_AXIS_* input stream
//        (TUSER [15:0] len, [23:16] src port, [31:24] dst port); M_AXIS_* output stream;
//        bad_csum_count / ttl_exp_count wrap-around counters of flagged IPv4 packets.
module ip_ttl_checksum_update
  import nf10_ip_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int BAD_CSUM_POS         = BAD_CSUM_POS_DEF,
  parameter int TTL_EXP_POS          = TTL_EXP_POS_DEF
) (
  input  logic                              AXI_ACLK,
  input  logic                              AXI_RESETN,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TLAST,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,

  output logic [31:0]                       bad_csum_count,
  output logic [31:0]                       ttl_exp_count
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int SW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  // Hold stage: one beat of lookahead so the last header word (bytes 0-1 of
  // beat 1) is available when beat 0 moves to the output register.
  logic [DW-1:0] hold_dat_q;
  logic [SW-1:0] hold_strb_q;
  logic [UW-1:0] hold_usr_q;
  logic          hold_last_q;
  logic          hold_first_q;
  logic          hold_vld_q, hold_vld_d;

  logic [DW-1:0] out_dat_q;
  logic [SW-1:0] out_strb_q;
  logic [UW-1:0] out_usr_q;
  logic          out_last_q;
  logic          out_vld_q;

  pkt_state_e    state_q, state_d;
  logic [31:0]   bad_cnt_q, bad_cnt_d;
  logic [31:0]   ttl_cnt_q, ttl_cnt_d;

  logic          advance;
  logic          s_hs;
  logic          shift;

  logic [HDR_WORDS-1:0][15:0] hdr_w;
  logic          csum_ok;
  logic [15:0]   new_csum;
  logic [7:0]    ttl;
  logic          eligible;
  logic          set_bad;
  logic          set_ttl;
  logic [DW-1:0] patch_dat;
  logic [UW-1:0] patch_usr;

  // ---------------------------------------------------------------- handshake
  assign advance       = !out_vld_q || M_AXIS_TREADY;
  assign S_AXIS_TREADY = advance;
  assign s_hs          = S_AXIS_TVALID && advance;
  // A non-last held beat waits for its successor (header lookahead); a held
  // last beat drains on its own so packets do not stall at the boundary.
  assign shift         = advance && hold_vld_q && (s_hs || hold_last_q);
  assign hold_vld_d    = s_hs || (hold_vld_q && !shift);

  always_comb begin
    state_d = state_q;
    if (s_hs) begin
      state_d = S_AXIS_TLAST ? ST_SOP : ST_BODY;
    end
  end

  // ---------------------------------------------------------- header datapath
  always_comb begin
    hdr_w = '0;
    for (int i = 0; i < HDR_WORDS - 1; i++) begin
      hdr_w[i] = hold_dat_q[DW-1-8*(IP_START_OFF+2*i) -: 16];
    end
    hdr_w[HDR_WORDS-1] = S_AXIS_TDATA[DW-1 -: 16];
  end

  ip_hdr_csum u_csum (
    .hdr_w_i    (hdr_w),
    .csum_ok_o  (csum_ok),
    .new_csum_o (new_csum)
  );

  assign ttl      = hold_dat_q[DW-1-8*TTL_OFF -: 8];
  // Single-beat packets are never eligible: the header's last word would sit
  // in a beat that does not exist.
  assign eligible = hold_first_q && !hold_last_q &&
                    (hold_dat_q[DW-1-8*ETHTYPE_OFF -: 16] == ETHERTYPE_IPV4) &&
                    (hold_dat_q[DW-1-8*IP_START_OFF -: 8] == IPV4_VER_IHL);

  always_comb begin
    patch_dat = hold_dat_q;
    patch_usr = hold_usr_q;
    set_bad   = 1'b0;
    set_ttl   = 1'b0;
    if (eligible) begin
      if (!csum_ok) begin
        set_bad = 1'b1;
      end else if (ttl <= 8'd1) begin
        set_ttl = 1'b1;
      end else begin
        patch_dat[DW-1-8*TTL_OFF -: 8]   = ttl - 8'd1;
        patch_dat[DW-1-8*CSUM_OFF -: 16] = new_csum;
      end
    end
    if (set_bad) patch_usr[BAD_CSUM_POS] = 1'b1;
    if (set_ttl) patch_usr[TTL_EXP_POS]  = 1'b1;
  end

  always_comb begin
    bad_cnt_d = bad_cnt_q;
    ttl_cnt_d = ttl_cnt_q;
    if (shift && set_bad) bad_cnt_d = bad_cnt_q + 32'd1;
    if (shift && set_ttl) ttl_cnt_d = ttl_cnt_q + 32'd1;
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
    if (!AXI_RESETN) begin
      state_q      <= ST_SOP;
      hold_vld_q   <= 1'b0;
      hold_dat_q   <= '0;
      hold_strb_q  <= '0;
      hold_usr_q   <= '0;
      hold_last_q  <= 1'b0;
      hold_first_q <= 1'b0;
      out_vld_q    <= 1'b0;
      out_dat_q    <= '0;
      out_strb_q   <= '0;
      out_usr_q    <= '0;
      out_last_q   <= 1'b0;
      bad_cnt_q    <= '0;
      ttl_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      hold_vld_q <= hold_vld_d;
      bad_cnt_q  <= bad_cnt_d;
      ttl_cnt_q  <= ttl_cnt_d;

      if (s_hs) begin
        hold_dat_q   <= S_AXIS_TDATA;
        hold_strb_q  <= S_AXIS_TSTRB;
        hold_usr_q   <= S_AXIS_TUSER;
        hold_last_q  <= S_AXIS_TLAST;
        hold_first_q <= (state_q == ST_SOP);
      end

      if (shift) begin
        out_vld_q  <= 1'b1;
        out_dat_q  <= patch_dat;
        out_strb_q <= hold_strb_q;
        out_usr_q  <= patch_usr;
        out_last_q <= hold_last_q;
      end else if (M_AXIS_TREADY) begin
        out_vld_q  <= 1'b0;
      end
    end
  end

  assign M_AXIS_TDATA   = out_dat_q;
  assign M_AXIS_TSTRB   = out_strb_q;
  assign M_AXIS_TUSER   = out_usr_q;
  assign M_AXIS_TLAST   = out_last_q;
  assign M_AXIS_TVALID  = out_vld_q;
  assign bad_csum_count = bad_cnt_q;
  assign ttl_exp_count  = ttl_cnt_q;

endmodule

// File: tb/tb_ip_ttl_checksum_update.sv
// Self-checking bench for ip_ttl_checksum_update using directed packets with hand-computed results.
// Latency: n/a.
// Backpressure: M_AXIS_TREADY held high or randomly toggled per scenario.
module tb_ip_ttl_checksum_update;

  typedef struct packed {
    logic [255:0] dat;
    logic [31:0]  strb;
    logic [127:0] usr;
    logic         last;
  } beat_t;

  logic         AXI_ACLK = 1'b0;
  logic         AXI_RESETN = 1'b0;
  logic [255:0] S_AXIS_TDATA = '0;
  logic [31:0]  S_AXIS_TSTRB = '0;
  logic [127:0] S_AXIS_TUSER = '0;
  logic         S_AXIS_TVALID = 1'b0;
  logic         S_AXIS_TREADY;
  logic         S_AXIS_TLAST = 1'b0;
  logic [255:0] M_AXIS_TDATA;
  logic [31:0]  M_AXIS_TSTRB;
  logic [127:0] M_AXIS_TUSER;
  logic         M_AXIS_TLAST;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TREADY = 1'b1;
  logic [31:0]  bad_csum_count;
  logic [31:0]  ttl_exp_count;

  ip_ttl_checksum_update dut (
    .AXI_ACLK       (AXI_ACLK),
    .AXI_RESETN     (AXI_RESETN),
    .S_AXIS_TDATA   (S_AXIS_TDATA),
    .S_AXIS_TSTRB   (S_AXIS_TSTRB),
    .S_AXIS_TUSER   (S_AXIS_TUSER),
    .S_AXIS_TVALID  (S_AXIS_TVALID),
    .S_AXIS_TREADY  (S_AXIS_TREADY),
    .S_AXIS_TLAST   (S_AXIS_TLAST),
    .M_AXIS_TDATA   (M_AXIS_TDATA),
    .M_AXIS_TSTRB   (M_AXIS_TSTRB),
    .M_AXIS_TUSER   (M_AXIS_TUSER),
    .M_AXIS_TLAST   (M_AXIS_TLAST),
    .M_AXIS_TVALID  (M_AXIS_TVALID),
    .M_AXIS_TREADY  (M_AXIS_TREADY),
    .bad_csum_count (bad_csum_count),
    .ttl_exp_count  (ttl_exp_count)
  );

  always #5 AXI_ACLK = ~AXI_ACLK;

  // Constants, all hand-derived from the header 4500 0073 0000 4000 4011 b861 c0a8 0001 c0a8 00c7.
  localparam logic [95:0]  MACS      = 96'h0011_2233_4455_6677_8899_aabb;
  localparam logic [143:0] HDR_OK    = 144'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8;
  localparam logic [143:0] HDR_PATCH = 144'h4500_0073_0000_4000_3f11_b961_c0a8_0001_c0a8;
  localparam logic [143:0] HDR_BAD   = 144'h4500_0073_0000_4000_4011_b862_c0a8_0001_c0a8;
  localparam logic [143:0] HDR_TTL1  = 144'h4500_0073_0000_4000_0111_f761_c0a8_0001_c0a8;
  localparam logic [255:0] BEAT1     = {16'h00c7, {15{16'ha5a5}}};
  localparam logic [255:0] BEAT2     = {16{16'h1234}};
  localparam logic [127:0] USR_IN    = 128'h0302_0040;
  localparam logic [127:0] USR_BAD   = 128'h1_0302_0040;
  localparam logic [127:0] USR_TTL   = 128'h2_0302_0040;
  localparam logic [31:0]  STRB_ALL  = 32'hFFFF_FFFF;
  localparam logic [31:0]  STRB_TAIL = 32'hFFFF_0000;

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;
  int    stalls = 0;
  bit    rand_rdy = 1'b0;
  beat_t got_q[$];
  beat_t exp_q[$];
  int    got_cyc_q[$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [255:0] d, input logic [31:0] s,
                               input logic [127:0] u, input logic l);
    beat_t b;
    b.dat = d; b.strb = s; b.usr = u; b.last = l;
    return b;
  endfunction

  always @(posedge AXI_ACLK) cyc <= cyc + 1;

  // Output monitor: values are stable at the falling edge for the next rising edge.
  always @(negedge AXI_ACLK) begin
    if (AXI_RESETN && M_AXIS_TVALID && M_AXIS_TREADY) begin
      got_q.push_back(mk(M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST));
      got_cyc_q.push_back(cyc);
    end
  end

  initial begin
    forever begin
      @(posedge AXI_ACLK);
      #1;
      if (rand_rdy) M_AXIS_TREADY = ($urandom_range(0, 2) != 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat was accepted.
  task automatic send_beat(input beat_t b);
    bit rdy;
    bit accepted;
    accepted = 1'b0;
    S_AXIS_TDATA  = b.dat;
    S_AXIS_TSTRB  = b.strb;
    S_AXIS_TUSER  = b.usr;
    S_AXIS_TLAST  = b.last;
    S_AXIS_TVALID = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge AXI_ACLK);
      rdy = S_AXIS_TREADY;
      @(posedge AXI_ACLK);
      #1;
      if (rdy) begin
        accepted = 1'b1;
        break;
      end
      stalls++;
    end
    if (!accepted) check_eq("send_timeout", 256'(accepted), 256'd1);
  endtask

  task automatic idle();
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic drain_and_compare(input string tag);
    beat_t g, e;
    int k;
    for (int i = 0; i < 400 && got_q.size() < exp_q.size(); i++) @(posedge AXI_ACLK);
    repeat (4) @(posedge AXI_ACLK);
    #1;
    check_eq({tag, "_nbeats"}, 256'(got_q.size()), 256'(exp_q.size()));
    k = 0;
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check_eq($sformatf("%s_b%0d_dat", tag, k), g.dat, e.dat);
      check_eq($sformatf("%s_b%0d_strb", tag, k), 256'(g.strb), 256'(e.strb));
      check_eq($sformatf("%s_b%0d_usr", tag, k), 256'(g.usr), 256'(e.usr));
      check_eq($sformatf("%s_b%0d_last", tag, k), 256'(g.last), 256'(e.last));
      k++;
    end
    got_q.delete();
    exp_q.delete();
    got_cyc_q.delete();
  endtask

  // Three-beat IPv4 packet with header hdr_in; expected beat 0 carries hdr_out/usr_out.
  task automatic ipv4_pkt(input logic [143:0] hdr_in, input logic [143:0] hdr_out,
                          input logic [127:0] usr_out);
    send_beat(mk({MACS, 16'h0800, hdr_in}, STRB_ALL, USR_IN, 1'b0));
    send_beat(mk(BEAT1, STRB_ALL, USR_IN, 1'b0));
    send_beat(mk(BEAT2, STRB_TAIL, USR_IN, 1'b1));
    idle();
    exp_q.push_back(mk({MACS, 16'h0800, hdr_out}, STRB_ALL, usr_out, 1'b0));
    exp_q.push_back(mk(BEAT1, STRB_ALL, USR_IN, 1'b0));
    exp_q.push_back(mk(BEAT2, STRB_TAIL, USR_IN, 1'b1));
  endtask

  task automatic two_beat_pkts(input int first, input int n);
    logic [255:0] d;
    for (int p = first; p < first + n; p++) begin
      for (int b = 0; b < 2; b++) begin
        d = {8{32'hC0DE_0000 + 32'(2 * p + b)}};
        send_beat(mk(d, STRB_ALL, USR_IN, b == 1));
        exp_q.push_back(mk(d, STRB_ALL, USR_IN, b == 1));
      end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge AXI_ACLK);
    #1;
    check_eq("rst_m_tvalid", 256'(M_AXIS_TVALID), 256'd0);
    check_eq("rst_m_tlast", 256'(M_AXIS_TLAST), 256'd0);
    check_eq("rst_m_tdata", M_AXIS_TDATA, 256'd0);
    check_eq("rst_m_tuser", 256'(M_AXIS_TUSER), 256'd0);
    check_eq("rst_s_tready", 256'(S_AXIS_TREADY), 256'd1);
    check_eq("rst_bad_cnt", 256'(bad_csum_count), 256'd0);
    check_eq("rst_ttl_cnt", 256'(ttl_exp_count), 256'd0);
    @(negedge AXI_ACLK);
    AXI_RESETN = 1'b1;
    @(posedge AXI_ACLK);
    #1;

    // Valid header: TTL 40 -> 3f, checksum b861 -> b961
    ipv4_pkt(HDR_OK, HDR_PATCH, USR_IN);
    drain_and_compare("ttl_dec");
    check_eq("ttl_dec_bad_cnt", 256'(bad_csum_count), 256'd0);
    check_eq("ttl_dec_ttl_cnt", 256'(ttl_exp_count), 256'd0);

    // Bad checksum: untouched data, flag bit 32
    ipv4_pkt(HDR_BAD, HDR_BAD, USR_BAD);
    drain_and_compare("bad_csum");
    check_eq("bad_csum_cnt", 256'(bad_csum_count), 256'd1);
    check_eq("bad_csum_ttl_cnt", 256'(ttl_exp_count), 256'd0);

    // TTL 01 with correct checksum f761: untouched data, flag bit 33
    ipv4_pkt(HDR_TTL1, HDR_TTL1, USR_TTL);
    drain_and_compare("ttl_exp");
    check_eq("ttl_exp_bad_cnt", 256'(bad_csum_count), 256'd1);
    check_eq("ttl_exp_cnt", 256'(ttl_exp_count), 256'd1);

    // ARP frame, then a single-beat IPv4 frame: both bit-exact, no flags
    send_beat(mk({MACS, 16'h0806, HDR_OK}, STRB_ALL, USR_IN, 1'b0));
    send_beat(mk(BEAT1, STRB_TAIL, USR_IN, 1'b1));
    send_beat(mk({MACS, 16'h0800, HDR_OK}, STRB_ALL, USR_IN, 1'b1));
    idle();
    exp_q.push_back(mk({MACS, 16'h0806, HDR_OK}, STRB_ALL, USR_IN, 1'b0));
    exp_q.push_back(mk(BEAT1, STRB_TAIL, USR_IN, 1'b1));
    exp_q.push_back(mk({MACS, 16'h0800, HDR_OK}, STRB_ALL, USR_IN, 1'b1));
    drain_and_compare("passthru");
    check_eq("passthru_bad_cnt", 256'(bad_csum_count), 256'd1);
    check_eq("passthru_ttl_cnt", 256'(ttl_exp_count), 256'd1);

    // Back-to-back 2-beat packets at full rate: 8 beats in 8 consecutive cycles
    stalls = 0;
    two_beat_pkts(0, 4);
    for (int i = 0; i < 100 && got_cyc_q.size() < 8; i++) @(posedge AXI_ACLK);
    #1;
    check_eq("tput_stalls", 256'(stalls), 256'd0);
    check_eq("tput_span", (got_cyc_q.size() >= 8) ? 256'(got_cyc_q[7] - got_cyc_q[0]) : '1,
             256'd7);
    drain_and_compare("tput");

    // Back-to-back 2-beat packets with random output back-pressure
    rand_rdy = 1'b1;
    two_beat_pkts(10, 8);
    rand_rdy = 1'b0;
    @(posedge AXI_ACLK);
    #1;
    M_AXIS_TREADY = 1'b1;
    drain_and_compare("rand_rdy");

    // Reset mid-packet with M_AXIS_TVALID high
    send_beat(mk({MACS, 16'h0800, HDR_OK}, STRB_ALL, USR_IN, 1'b0));
    send_beat(mk(BEAT1, STRB_ALL, USR_IN, 1'b0));
    idle();
    #2;
    check_eq("pre_rst_tvalid", 256'(M_AXIS_TVALID), 256'd1);
    AXI_RESETN = 1'b0;
    #1;
    check_eq("mid_rst_tvalid", 256'(M_AXIS_TVALID), 256'd0);
    check_eq("mid_rst_tlast", 256'(M_AXIS_TLAST), 256'd0);
    check_eq("mid_rst_bad_cnt", 256'(bad_csum_count), 256'd0);
    check_eq("mid_rst_ttl_cnt", 256'(ttl_exp_count), 256'd0);
    repeat (2) @(negedge AXI_ACLK);
    AXI_RESETN = 1'b1;
    @(posedge AXI_ACLK);
    #1;
    got_q.delete();
    got_cyc_q.delete();
    ipv4_pkt(HDR_OK, HDR_PATCH, USR_IN);
    drain_and_compare("post_rst");
    check_eq("post_rst_bad_cnt", 256'(bad_csum_count), 256'd0);
    check_eq("post_rst_ttl_cnt", 256'(ttl_exp_count), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
